// File: rtl/booth_r4_seq_mult_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier: FSM states,
// Booth digit codes and the digit-count / accumulator-width derivations.
package booth_r4_seq_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_t;

    // One extra digit so the zero-extended unsigned operand still ends on a zero digit.
    function automatic int booth_ndig(input int n);
        return n / 32'sd2 + 32'sd1;
    endfunction

    function automatic int booth_acc_w(input int n);
        return 32'sd2 * n + 32'sd2;
    endfunction

    function automatic booth_digit_t booth_decode(input logic [2:0] d);
        booth_digit_t code;
        case (d)
            3'b000, 3'b111: code = BD_ZERO;
            3'b001, 3'b010: code = BD_P1;
            3'b011:         code = BD_P2;
            3'b100:         code = BD_M2;
            3'b101, 3'b110: code = BD_M1;
            default:        code = BD_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_r4_seq_mult_digit.sv
// Combinational radix-4 Booth partial-product generator: maps one 3-bit
// digit window and the extended multiplicand to 0, +/-ys or +/-2ys.
module booth_r4_digit
    import booth_r4_seq_mult_pkg::*;
#(
    parameter int ACC_W = 34
)
(
    input  logic [2:0]       digit,
    input  logic [ACC_W-1:0] ys,
    output logic [ACC_W-1:0] pp
);

    booth_digit_t     code_s;
    logic [ACC_W-1:0] ys2_s;

    // Select the partial product; negation is two's complement modulo 2^ACC_W.
    always_comb begin
        code_s = booth_decode(digit);
        ys2_s  = ys << 1;
        pp     = {ACC_W{1'b0}};
        case (code_s)
            BD_ZERO: pp = {ACC_W{1'b0}};
            BD_P1:   pp = ys;
            BD_P2:   pp = ys2_s;
            BD_M1:   pp = ~ys + ACC_W'(1'b1);
            BD_M2:   pp = ~ys2_s + ACC_W'(1'b1);
            default: pp = {ACC_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Multi-cycle radix-4 Booth multiplier, one digit per clock, signed/unsigned per operation.
// Optional `BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all zero.
module booth_r4_seq_mult
    import booth_r4_seq_mult_pkg::*;
#(
    parameter int N = 16
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           is_signed,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result
);

    localparam int NDIG  = booth_ndig(N);
    localparam int ACC_W = booth_acc_w(N);
    localparam int XW    = 2 * NDIG;
    localparam int XS_W  = XW + 1;
    localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t           state_r;
    logic [XS_W-1:0]  xs_r;
    logic [ACC_W-1:0] ys_r;
    logic [ACC_W-1:0] acc_r;
    logic [DIG_W-1:0] dig_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [2*N-1:0]   result_r;

    logic [XW-1:0]    x_ext_s;
    logic [ACC_W-1:0] y_ext_s;
    logic [ACC_W-1:0] pp_s;
    logic [ACC_W-1:0] pp_shift_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [XS_W-1:0]  xs_next_s;
    logic             last_s;
    logic             stop_s;

    booth_r4_digit #(
        .ACC_W (ACC_W)
    ) u_digit (
        .digit (xs_r[2:0]),
        .ys    (ys_r),
        .pp    (pp_s)
    );

    // Operand extension, accumulator update and termination decision.
    always_comb begin
        x_ext_s    = {{(XW - N){is_signed & x[N-1]}}, x};
        y_ext_s    = {{(ACC_W - N){is_signed & y[N-1]}}, y};
        pp_shift_s = pp_s << {dig_r, 1'b0};
        acc_next_s = acc_r + pp_shift_s;
        xs_next_s  = {{2{xs_r[XS_W-1]}}, xs_r[XS_W-1:2]};
        last_s     = (dig_r == DIG_W'(NDIG - 1));
`ifdef BOOTH_EARLY_TERM_EN
        // Uniform remaining bits (overlap bit included) decode only to zero digits.
        stop_s     = last_s || (xs_next_s == {XS_W{1'b0}}) || (xs_next_s == {XS_W{1'b1}});
`else
        stop_s     = last_s;
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            xs_r        <= {XS_W{1'b0}};
            ys_r        <= {ACC_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            dig_r       <= {DIG_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {(2 * N){1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        xs_r       <= {x_ext_s, 1'b0};
                        ys_r       <= y_ext_s;
                        acc_r      <= {ACC_W{1'b0}};
                        dig_r      <= {DIG_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_r <= acc_next_s;
                    xs_r  <= xs_next_s;
                    dig_r <= dig_r + DIG_W'(1'b1);
                    if (stop_s) begin
                        out_valid_r <= 1'b1;
                        result_r    <= acc_next_s[2*N-1:0];
                        state_r     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready must read low for the whole time reset is asserted.
    assign in_ready  = in_ready_r & rst_n;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule
